// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converters.
//   b2b_state_t : control states of the sequential converter
//   add3_adj    : double-dabble digit correction (d >= 5 -> d + 3)
//   BCD_NINES   : all-nines pattern, sliced to the digit count for saturation
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

    // Widest digit count any converter instance may use.
    localparam int unsigned MAX_DIGITS = 32;

    localparam logic [4*MAX_DIGITS-1:0] BCD_NINES = {MAX_DIGITS{4'h9}};

    function automatic logic [3:0] add3_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_stage.sv
// Combinational double-dabble correction stage: applies add3_adj to every
// nibble of a packed BCD vector.
//   bcd_in  : packed BCD digits, digit 0 in [3:0]
//   bcd_adj : same digits after the +3 correction
module bcd_dabble_stage
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 8
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic [4*DIGITS-1:0] bcd_adj
);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign bcd_adj[4*i +: 4] = add3_adj(bcd_in[4*i +: 4]);
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one shift-and-add-3 step per clock.
//   CLK100MHZ  : system clock
//   CPU_RESETN : asynchronous active-low reset
//   start      : conversion request, only honoured while idle
//   bin_in     : unsigned operand, captured on the accepting edge
//   busy       : high while shifting and during the done cycle
//   done       : one-cycle pulse when bcd_out/overflow are fresh
//   bcd_out    : packed BCD result (digit 0 in [3:0]), held until next result
//   overflow   : result exceeded DIGITS digits; bcd_out saturates to all nines
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH_BIN = 20,
    parameter int unsigned DIGITS    = 8
) (
    input  logic                   CLK100MHZ,
    input  logic                   CPU_RESETN,
    input  logic                   start,
    input  logic [WIDTH_BIN-1:0]   bin_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic                   overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + WIDTH_BIN;
    localparam int unsigned CNT_W = $clog2(WIDTH_BIN + 1);

    b2b_state_t         state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               overflow_q, overflow_d;

    logic [BCD_W-1:0]   bcd_adj;
    // Extra top bit catches the bit shifted out of the most significant digit.
    logic [SR_W:0]      shifted;
    logic               ovf_next;

    bcd_dabble_stage #(
        .DIGITS (DIGITS)
    ) u_dabble (
        .bcd_in  (sr_q[SR_W-1 -: BCD_W]),
        .bcd_adj (bcd_adj)
    );

    assign shifted  = {bcd_adj, sr_q[WIDTH_BIN-1:0], 1'b0};
    assign ovf_next = ovf_acc_q | shifted[SR_W];

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        bcd_out_d  = bcd_out_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    sr_d      = {{BCD_W{1'b0}}, bin_in};
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(WIDTH_BIN - 1);
                end
            end
            SHIFT: begin
                sr_d      = shifted[SR_W-1:0];
                ovf_acc_d = ovf_next;
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    overflow_d = ovf_next;
                    bcd_out_d  = ovf_next ? BCD_NINES[BCD_W-1:0] : shifted[SR_W-1 -: BCD_W];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            bcd_out_q  <= bcd_out_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign bcd_out  = bcd_out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;

    logic        start4;
    logic [19:0] bin4;
    logic        busy4;
    logic        done4;
    logic [15:0] bcd4;
    logic        ovf4;

    int compared;
    int mismatched;
    int cyc;

    bin_to_bcd_seq #(
        .WIDTH_BIN (20),
        .DIGITS    (8)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .overflow   (overflow)
    );

    bin_to_bcd_seq #(
        .WIDTH_BIN (20),
        .DIGITS    (4)
    ) dut4 (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .start      (start4),
        .bin_in     (bin4),
        .busy       (busy4),
        .done       (done4),
        .bcd_out    (bcd4),
        .overflow   (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model8(input int unsigned v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One conversion on the 8-digit instance; optionally pulses start with
    // another operand at negedge number poke_at after the accepting edge.
    task automatic run_one(input logic [19:0] v, input int poke_at, input logic [19:0] poke_v,
                           output int lat, output int busy_n, output int done_n,
                           output logic [31:0] res, output logic ovf);
        lat = -1; busy_n = 0; done_n = 0; res = '0; ovf = 1'b0;
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = (i == poke_at);
            if (i == poke_at) bin_in = poke_v;
            else if (i == 1)  bin_in = v ^ 20'h5A5A5;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = i;
                    res = bcd_out;
                    ovf = overflow;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic run_four(input logic [19:0] v, output logic [15:0] res, output logic ovf,
                            output int done_n);
        res = '0; ovf = 1'b0; done_n = 0;
        @(negedge clk);
        bin4   = v;
        start4 = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4) begin
                done_n++;
                res = bcd4;
                ovf = ovf4;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; bin_in = '0; start4 = 1'b0; bin4 = '0;
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
        compared++;
        if (bcd_out !== 32'h0) begin
            mismatched++; $display("FAIL reset_bcd got %h want 00000000", bcd_out);
        end
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++; $display("FAIL reset_ovf got %b want 0", overflow);
        end
        compared++;
        if ({busy4, done4, bcd4, ovf4} !== 19'h0) begin
            mismatched++; $display("FAIL reset_dut4 got %h want 0", {busy4, done4, bcd4, ovf4});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, busy_n, done_n;
        logic [31:0] res;
        logic ovf;
        run_one(20'h5EC50, -1, 20'h0, lat, busy_n, done_n, res, ovf);
        compared++;
        if (lat !== 21) begin mismatched++; $display("FAIL basic_latency got %0d want 21", lat); end
        compared++;
        if (res !== 32'h00388176) begin
            mismatched++; $display("FAIL basic_bcd got %h want 00388176", res);
        end
        compared++;
        if (ovf !== 1'b0) begin mismatched++; $display("FAIL basic_ovf got %b want 0", ovf); end
        compared++;
        if (done_n !== 1) begin mismatched++; $display("FAIL basic_done_count got %0d want 1", done_n); end
        compared++;
        if (busy_n !== 21) begin mismatched++; $display("FAIL basic_busy got %0d want 21", busy_n); end
        compared++;
        if (bcd_out !== 32'h00388176) begin
            mismatched++; $display("FAIL basic_hold got %h want 00388176", bcd_out);
        end
    endtask

    task automatic test_extremes;
        int lat, busy_n, done_n;
        logic [31:0] res;
        logic ovf;
        run_one(20'h00000, -1, 20'h0, lat, busy_n, done_n, res, ovf);
        compared++;
        if (res !== 32'h00000000) begin
            mismatched++; $display("FAIL zero_bcd got %h want 00000000", res);
        end
        compared++;
        if (busy_n !== 21) begin mismatched++; $display("FAIL zero_busy got %0d want 21", busy_n); end
        run_one(20'hFFFFF, -1, 20'h0, lat, busy_n, done_n, res, ovf);
        compared++;
        if (res !== 32'h01048575) begin
            mismatched++; $display("FAIL max_bcd got %h want 01048575", res);
        end
        compared++;
        if (busy_n !== 21) begin mismatched++; $display("FAIL max_busy got %0d want 21", busy_n); end
        compared++;
        if (ovf !== 1'b0) begin mismatched++; $display("FAIL max_ovf got %b want 0", ovf); end
    endtask

    task automatic test_overflow;
        logic [15:0] res;
        logic ovf;
        int done_n;
        run_four(20'd10000, res, ovf, done_n);
        compared++;
        if (ovf !== 1'b1) begin mismatched++; $display("FAIL ovf10000_flag got %b want 1", ovf); end
        compared++;
        if (res !== 16'h9999) begin mismatched++; $display("FAIL ovf10000_bcd got %h want 9999", res); end
        run_four(20'd9999, res, ovf, done_n);
        compared++;
        if (ovf !== 1'b0) begin mismatched++; $display("FAIL ovf9999_flag got %b want 0", ovf); end
        compared++;
        if (res !== 16'h9999) begin mismatched++; $display("FAIL ovf9999_bcd got %h want 9999", res); end
        run_four(20'd1234, res, ovf, done_n);
        compared++;
        if ({ovf, res} !== {1'b0, 16'h1234}) begin
            mismatched++; $display("FAIL ovf1234 got %b/%h want 0/1234", ovf, res);
        end
        run_four(20'd65535, res, ovf, done_n);
        compared++;
        if ({ovf, res} !== {1'b1, 16'h9999}) begin
            mismatched++; $display("FAIL ovf65535 got %b/%h want 1/9999", ovf, res);
        end
    endtask

    task automatic test_ignore_start;
        int lat, busy_n, done_n;
        logic [31:0] res;
        logic ovf;
        run_one(20'd123456, 6, 20'd999, lat, busy_n, done_n, res, ovf);
        compared++;
        if (res !== 32'h00123456) begin
            mismatched++; $display("FAIL ignore_bcd got %h want 00123456", res);
        end
        compared++;
        if (done_n !== 1) begin mismatched++; $display("FAIL ignore_done_count got %0d want 1", done_n); end
    endtask

    task automatic test_reset_mid;
        int lat, busy_n, done_n;
        logic [31:0] res;
        logic ovf;
        int seen_done;
        @(negedge clk);
        bin_in = 20'd777777;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        // Counter reaches 10 after the ninth shift edge.
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({busy, done, bcd_out, overflow} !== 35'h0) begin
            mismatched++;
            $display("FAIL rstmid_outputs got busy=%b done=%b bcd=%h ovf=%b want all 0",
                     busy, done, bcd_out, overflow);
        end
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        compared++;
        if (seen_done !== 0) begin mismatched++; $display("FAIL rstmid_no_done got %0d want 0", seen_done); end
        run_one(20'd54321, -1, 20'h0, lat, busy_n, done_n, res, ovf);
        compared++;
        if (res !== 32'h00054321) begin
            mismatched++; $display("FAIL rstmid_fresh got %h want 00054321", res);
        end
        compared++;
        if (lat !== 21) begin mismatched++; $display("FAIL rstmid_latency got %0d want 21", lat); end
    endtask

    task automatic test_back_to_back;
        logic [19:0] exp_v;
        logic prev_done;
        int prev_cyc;
        bit got;
        prev_done = 1'b0;
        prev_cyc  = 0;
        @(negedge clk);
        exp_v  = 20'($urandom_range(0, 20'hFFFFF));
        bin_in = exp_v;
        start  = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    compared++;
                    if (prev_done) begin
                        mismatched++; $display("FAIL b2b_double_done at conversion %0d", n);
                    end
                    compared++;
                    if (bcd_out !== model8(32'(exp_v))) begin
                        mismatched++;
                        $display("FAIL b2b_bcd[%0d] in=%0d got %h want %h",
                                 n, exp_v, bcd_out, model8(32'(exp_v)));
                    end
                    if (n > 0) begin
                        compared++;
                        if (cyc - prev_cyc !== 22) begin
                            mismatched++;
                            $display("FAIL b2b_period[%0d] got %0d want 22", n, cyc - prev_cyc);
                        end
                    end
                    prev_cyc = cyc;
                    exp_v  = 20'($urandom_range(0, 20'hFFFFF));
                    bin_in = exp_v;
                end
                prev_done = done;
            end
            if (!got) begin
                compared++;
                mismatched++;
                $display("FAIL b2b_timeout conversion %0d got no done want done", n);
                break;
            end
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
